// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and widths for the data-memory arbiter
package dmem_arb_pkg;

  localparam int DEF_WORD_LEN = 32;
  localparam int STARVE_W     = 4;
  localparam int LAT_W        = 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BUSY_CPU = 3'd1,
    BUSY_DBG = 3'd2,
    CPU_DONE = 3'd3,
    DBG_DONE = 3'd4
  } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_lat_counter.sv
// rtl/dmem_arbiter_lat_counter.sv - memory read latency down-counter with zero flag
module arb_lat_counter
  import dmem_arb_pkg::*;
#(
  parameter int LOAD_VAL = 2
) (
  input  logic clk,
  input  logic nReset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [LAT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LAT_W'(LOAD_VAL);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data memory shared by the CPU MEM stage and a loader/debug master
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int WORD_LEN   = DEF_WORD_LEN,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic                cpu_rd,
  input  logic                cpu_wr,
  input  logic [WORD_LEN-1:0] cpu_addr,
  input  logic [WORD_LEN-1:0] cpu_wdata,
  output logic [WORD_LEN-1:0] cpu_rdata,
  output logic                cpu_stall,
  input  logic                dbg_req,
  input  logic                dbg_we,
  input  logic [WORD_LEN-1:0] dbg_addr,
  input  logic [WORD_LEN-1:0] dbg_wdata,
  output logic                dbg_gnt,
  output logic                dbg_done,
  output logic [WORD_LEN-1:0] dbg_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [WORD_LEN-1:0] mem_addr,
  output logic [WORD_LEN-1:0] mem_wdata,
  input  logic [WORD_LEN-1:0] mem_rdata
);

  arb_state_t          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [WORD_LEN-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_LEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [WORD_LEN-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [WORD_LEN-1:0] dbg_rdata_q, dbg_rdata_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic                dbg_gnt_q, dbg_gnt_d;
  logic                dbg_done_q, dbg_done_d;

  logic cpu_req;
  logic pick_dbg;
  logic lat_load;
  logic lat_dec;
  logic lat_zero;

  assign cpu_req  = cpu_rd | cpu_wr;
  assign lat_dec  = (state_q == BUSY_CPU) || (state_q == BUSY_DBG);
  // Debug only wins a tie once the CPU has been granted STARVE_MAX times in a row.
  assign pick_dbg = dbg_req && (!cpu_req || (starve_q == STARVE_W'(STARVE_MAX)));

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    dbg_gnt_d   = 1'b0;
    dbg_done_d  = 1'b0;
    lat_load    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!dbg_req) begin
          starve_d = '0;
        end
        if (pick_dbg) begin
          state_d     = BUSY_DBG;
          mem_addr_d  = dbg_addr;
          mem_wdata_d = dbg_wdata;
          mem_en_d    = 1'b1;
          mem_we_d    = dbg_we;
          dbg_gnt_d   = 1'b1;
          starve_d    = '0;
          lat_load    = 1'b1;
        end else if (cpu_req) begin
          state_d     = BUSY_CPU;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          mem_en_d    = 1'b1;
          mem_we_d    = cpu_wr;
          lat_load    = 1'b1;
          if (dbg_req && (starve_q != {STARVE_W{1'b1}})) begin
            starve_d = starve_q + 1'b1;
          end
        end
      end
      // The access completes even if the CPU request went away meanwhile.
      BUSY_CPU: begin
        if (lat_zero) begin
          cpu_rdata_d = mem_rdata;
          state_d     = CPU_DONE;
        end
      end
      BUSY_DBG: begin
        if (lat_zero) begin
          dbg_rdata_d = mem_rdata;
          dbg_done_d  = 1'b1;
          state_d     = DBG_DONE;
        end
      end
      CPU_DONE: state_d = IDLE;
      DBG_DONE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      dbg_gnt_q   <= 1'b0;
      dbg_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      dbg_gnt_q   <= dbg_gnt_d;
      dbg_done_q  <= dbg_done_d;
    end
  end

  arb_lat_counter #(
    .LOAD_VAL (MEM_LAT)
  ) u_lat_counter (
    .clk    (clk),
    .nReset (nReset),
    .load   (lat_load),
    .dec    (lat_dec),
    .zero   (lat_zero)
  );

  // Gated by nReset so the stall also drops while reset is held.
  assign cpu_stall = nReset && cpu_req && (state_q != CPU_DONE);
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign dbg_gnt   = dbg_gnt_q;
  assign dbg_done  = dbg_done_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

  localparam int WL   = 32;
  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          nReset;
  logic          cpu_rd, cpu_wr;
  logic [WL-1:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          dbg_req, dbg_we;
  logic [WL-1:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic          dbg_gnt, dbg_done;
  logic          mem_en, mem_we;
  logic [WL-1:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  logic [WL-1:0] cpu_exp_q[$];
  logic [WL-1:0] dbg_exp_q[$];
  logic [WL-1:0] ref_mem[256];

  always #5 clk = ~clk;

  dmem_arbiter #(
    .WORD_LEN   (WL),
    .MEM_LAT    (LAT),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk       (clk),
    .nReset    (nReset),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_gnt   (dbg_gnt),
    .dbg_done  (dbg_done),
    .dbg_rdata (dbg_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [WL-1:0] init_word(input logic [7:0] i);
    return (i == 8'h04) ? 32'hDEADBEEF : ({4{i}} ^ 32'h5A5A0000);
  endfunction

  // Memory responder: read data appears LAT cycles after the strobe cycle.
  logic [WL-1:0] mem[256];
  logic          written[256];
  logic [WL-1:0] rd_pipe[LAT];
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem[mem_addr[9:2]]     <= mem_wdata;
      written[mem_addr[9:2]] <= 1'b1;
    end
    rd_pipe[0] <= !mem_en ? 32'h0 :
                  (written[mem_addr[9:2]] === 1'b1) ? mem[mem_addr[9:2]] : init_word(mem_addr[9:2]);
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  task automatic check(input string tag, input logic [WL-1:0] obs, input logic [WL-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cpu_access(input logic [WL-1:0] a, input logic [WL-1:0] d, input logic rd, input logic wr,
                            output int stalls, output int en_at, output int en_cnt,
                            output logic we_at_en, output logic [WL-1:0] addr_at_en);
    logic is_read;
    @(negedge clk);
    is_read = rd && !wr;
    if (is_read) cpu_exp_q.push_back(ref_mem[a[9:2]]);
    else ref_mem[a[9:2]] = d;
    cpu_addr = a; cpu_wdata = d; cpu_rd = rd; cpu_wr = wr;
    stalls = 0; en_at = -1; en_cnt = 0; we_at_en = 1'b0; addr_at_en = '0;
    #1;
    for (int c = 0; c < 20; c++) begin
      if (mem_en) begin
        en_cnt++;
        if (en_at < 0) begin
          en_at = c; we_at_en = mem_we; addr_at_en = mem_addr;
        end
      end
      if (!cpu_stall) break;
      stalls++;
      @(negedge clk);
    end
    if (is_read) check("cpu_rdata", cpu_rdata, cpu_exp_q.pop_front());
    cpu_rd = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic dbg_access(input logic [WL-1:0] a, input logic [WL-1:0] d, input logic we,
                            output int gnt_at, output logic en_at_gnt, output logic we_at_gnt,
                            output logic [WL-1:0] addr_at_gnt, output int done_after);
    @(negedge clk);
    if (!we) dbg_exp_q.push_back(ref_mem[a[9:2]]);
    else ref_mem[a[9:2]] = d;
    dbg_addr = a; dbg_wdata = d; dbg_we = we; dbg_req = 1'b1;
    gnt_at = -1; done_after = -1; en_at_gnt = 1'b0; we_at_gnt = 1'b0; addr_at_gnt = '0;
    #1;
    for (int c = 0; c < 20; c++) begin
      if (dbg_gnt) begin
        gnt_at = c; en_at_gnt = mem_en; we_at_gnt = mem_we; addr_at_gnt = mem_addr;
        dbg_req = 1'b0;
        break;
      end
      @(negedge clk);
    end
    dbg_req = 1'b0;
    if (gnt_at >= 0) begin
      for (int c = 1; c < 20; c++) begin
        @(negedge clk);
        if (dbg_done) begin
          done_after = c;
          break;
        end
      end
    end
    if (!we) check("dbg_rdata", dbg_rdata, dbg_exp_q.pop_front());
  endtask

  // Both masters request continuously; own[i] records whether access i went to debug.
  task automatic run_both(input int n, output logic [15:0] own, output int got, output logic late_gnt);
    @(negedge clk);
    cpu_addr = 32'h10; cpu_rd = 1'b1; cpu_wr = 1'b0;
    dbg_addr = 32'h80; dbg_we = 1'b0; dbg_req = 1'b1;
    own = '0; got = 0; late_gnt = 1'b0;
    #1;
    for (int c = 0; c < 200 && got < n; c++) begin
      if (mem_en) begin
        own[got] = dbg_gnt;
        got++;
      end
      if (got < n) @(negedge clk);
    end
    cpu_rd = 1'b0; dbg_req = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (dbg_gnt) late_gnt = 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls, en_at, en_cnt, gnt_at, done_after, got;
    logic we_at, en_g, we_g, late, gnt_seen;
    logic [WL-1:0] addr_at;
    logic [15:0] own;

    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
    nReset = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

    repeat (3) @(negedge clk);
    check("rst_mem_en", {31'b0, mem_en}, 32'h0);
    check("rst_cpu_stall", {31'b0, cpu_stall}, 32'h0);
    check("rst_dbg_gnt_done", {30'b0, dbg_gnt, dbg_done}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_dbg_rdata", dbg_rdata, 32'h0);
    nReset = 1'b1;

    // CPU load from 0x10
    cpu_access(32'h10, 32'h0, 1'b1, 1'b0, stalls, en_at, en_cnt, we_at, addr_at);
    check("ld_stalls", 32'(stalls), 32'(LAT + 2));
    check("ld_en_at", 32'(en_at), 32'd1);
    check("ld_en_cnt", 32'(en_cnt), 32'd1);
    check("ld_we", {31'b0, we_at}, 32'h0);
    check("ld_addr", addr_at, 32'h10);

    // rd and wr together act as a store
    cpu_access(32'h20, 32'hCAFEF00D, 1'b1, 1'b1, stalls, en_at, en_cnt, we_at, addr_at);
    check("rdwr_we", {31'b0, we_at}, 32'h1);
    check("rdwr_stalls", 32'(stalls), 32'(LAT + 2));
    cpu_access(32'h20, 32'h0, 1'b1, 1'b0, stalls, en_at, en_cnt, we_at, addr_at);

    // debug write then read back
    dbg_access(32'h40, 32'h12345678, 1'b1, gnt_at, en_g, we_g, addr_at, done_after);
    check("dw_gnt_at", 32'(gnt_at), 32'd1);
    check("dw_en_we", {30'b0, en_g, we_g}, 32'h3);
    check("dw_addr", addr_at, 32'h40);
    check("dw_done_after", 32'(done_after), 32'd3);
    dbg_access(32'h40, 32'h0, 1'b0, gnt_at, en_g, we_g, addr_at, done_after);
    check("dr_we", {30'b0, en_g, we_g}, 32'h2);
    check("dr_done_after", 32'(done_after), 32'd3);

    // continuous contention: four CPU accesses then one debug
    run_both(10, own, got, late);
    check("fair_got", 32'(got), 32'd10);
    for (int i = 0; i < 10; i++) check($sformatf("fair_owner_%0d", i), {31'b0, own[i]}, {31'b0, (i % 5) == 4});

    // debug request appearing and vanishing inside a CPU access
    @(negedge clk);
    cpu_addr = 32'h10; cpu_rd = 1'b1;
    @(negedge clk);
    dbg_addr = 32'h80; dbg_req = 1'b1;
    @(negedge clk);
    dbg_req = 1'b0;
    gnt_seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (!cpu_stall) cpu_rd = 1'b0;
      if (dbg_gnt) gnt_seen = 1'b1;
    end
    check("cancel_no_gnt", {31'b0, gnt_seen}, 32'h0);

    // build starvation to 3, withdraw debug mid-access, expect the count to restart
    run_both(3, own, got, late);
    check("starve3_owners", {29'b0, own[2:0]}, 32'h0);
    check("starve3_no_late_gnt", {31'b0, late}, 32'h0);
    run_both(5, own, got, late);
    check("starve_cleared_owners", {27'b0, own[4:0]}, 32'h10);

    // reset in the second busy cycle of a CPU access
    @(negedge clk);
    cpu_addr = 32'h10; cpu_wdata = 32'hA5A5A5A5; cpu_rd = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("hold_mem_addr", mem_addr, 32'h10);
    check("hold_mem_wdata", mem_wdata, 32'hA5A5A5A5);
    nReset = 1'b0;
    #1;
    check("arst_mem_addr", mem_addr, 32'h0);
    check("arst_mem_wdata", mem_wdata, 32'h0);
    check("arst_cpu_rdata", cpu_rdata, 32'h0);
    check("arst_dbg_rdata", dbg_rdata, 32'h0);
    check("arst_strobes", {27'b0, mem_en, mem_we, dbg_gnt, dbg_done, cpu_stall}, 32'h0);
    cpu_rd = 1'b0;
    repeat (2) @(negedge clk);
    nReset = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {30'b0, mem_en, cpu_stall}, 32'h0);
    cpu_access(32'h10, 32'h0, 1'b1, 1'b0, stalls, en_at, en_cnt, we_at, addr_at);
    check("post_rst_stalls", 32'(stalls), 32'(LAT + 2));
    check("post_rst_en_at", 32'(en_at), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter WORD_LEN, default 32, data/address width.
REQ-002 SHALL have parameter MEM_LAT, default 2, memory read latency in cycles (legal 1..7).
REQ-003 SHALL have parameter STARVE_MAX, default 4, consecutive CPU grants allowed while debug waits (legal 1..15).
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports as below.
REQ-005 SHALL have port clk  in  1  clock, all state updates on rising edge.
REQ-006 SHALL have port nReset  in  1  asynchronous active-low reset.
REQ-007 SHALL have port cpu_rd  in  1  MEM-stage load request (Mem_R_En).
REQ-008 SHALL have port cpu_wr  in  1  MEM-stage store request (Mem_W_En).
REQ-009 SHALL have ports cpu_addr and cpu_wdata  in  WORD_LEN each  MEM-stage address (ALU result) and store data.
REQ-010 SHALL have port cpu_rdata  out  WORD_LEN  load data.
REQ-011 SHALL have port cpu_stall  out  1  freeze the pipeline.
REQ-012 SHALL have ports dbg_req, dbg_we  in  1 each  loader/debug request and write select.
REQ-013 SHALL have ports dbg_addr and dbg_wdata  in  WORD_LEN each  loader/debug address and write data.
REQ-014 SHALL have ports dbg_gnt and dbg_done  out  1 each  accept pulse and completion pulse.
REQ-015 SHALL have port dbg_rdata  out  WORD_LEN  loader/debug read data.
REQ-016 SHALL have ports mem_en and mem_we  out  1 each  memory strobe and write enable.
REQ-017 SHALL have ports mem_addr and mem_wdata  out  WORD_LEN each  memory address and write data.
REQ-018 SHALL have port mem_rdata  in  WORD_LEN  valid MEM_LAT cycles after the mem_en cycle.

Function
REQ-019 SHALL implement the FSM states IDLE, BUSY_CPU, BUSY_DBG, CPU_DONE and DBG_DONE.
REQ-020 IDLE arbitration SHALL work as follows: CPU request = cpu_rd|cpu_wr; with a CPU request only, enter BUSY_CPU; with dbg_req only, enter BUSY_DBG; with both, enter BUSY_CPU unless starve_cnt==STARVE_MAX, in which case enter BUSY_DBG.
REQ-021 On entering BUSY_x, the block SHALL register the owner's addr/wdata into mem_addr/mem_wdata, held constant through BUSY_x.
REQ-022 mem_en SHALL be high for exactly the first BUSY_x cycle only.
REQ-023 mem_we SHALL be high for the first BUSY_x cycle of a write.
REQ-024 If cpu_rd and cpu_wr are both high, the access SHALL be a write.
REQ-025 The latency counter SHALL be loaded with MEM_LAT on BUSY entry and decrement each BUSY cycle; at cnt==0 the block SHALL capture mem_rdata into the owner's rdata register and go to x_DONE.
REQ-026 Writes SHALL use identical timing; for writes, rdata capture SHALL be performed but the value is don't-care.
REQ-027 CPU_DONE and DBG_DONE SHALL last one cycle and then return to IDLE; no arbitration SHALL occur in the DONE states.
REQ-028 cpu_stall SHALL equal (cpu_rd|cpu_wr) && state!=CPU_DONE (combinational), giving MEM_LAT+2 stall cycles per CPU access with no contention.
REQ-029 cpu_rdata SHALL be registered and valid in CPU_DONE, holding until the next CPU capture.
REQ-030 dbg_gnt SHALL pulse in the first BUSY_DBG cycle; dbg_done SHALL pulse in DBG_DONE with dbg_rdata valid, holding until the next debug capture.
REQ-031 dbg_req SHALL be held by the requester until dbg_gnt; a dbg_req drop before grant SHALL cancel the request silently.
REQ-032 starve_cnt (4 bits) SHALL increment, saturating, on each BUSY_CPU entry while dbg_req is high, and clear on BUSY_DBG entry or when dbg_req is low in IDLE.
REQ-033 A CPU request dropped mid-BUSY_CPU SHALL still complete its access, with the result discarded.

Reset
REQ-034 nReset low SHALL immediately force state IDLE, cnt=0, starve_cnt=0, and all outputs 0 (cpu_rdata, dbg_rdata, mem_addr, mem_wdata included).
REQ-035 An access interrupted by reset SHALL be abandoned and not retried; the memory contents at the aborted address are undefined.

Structure
REQ-036 A shared package dmem_arb_pkg SHALL hold typedef arb_state_t (five states) and the STARVE counter width; WORD_LEN SHALL come from the existing constants include.
REQ-037 There SHALL be one sub-module, arb_lat_counter (load/decrement/zero flag), with everything else in dmem_arbiter.

Verification
REQ-038 Scenario: CPU load addr 0x10, mem returns 0xDEADBEEF, MEM_LAT=2 -> mem_en one cycle after request; cpu_stall high 4 cycles; cpu_rdata=0xDEADBEEF in CPU_DONE.
REQ-039 Scenario: debug write addr 0x40 data 0x12345678 -> dbg_gnt pulse with mem_en=mem_we=1, mem_addr=0x40; dbg_done 3 cycles later.
REQ-040 Scenario: CPU and debug request continuously, STARVE_MAX=4 -> exactly 4 CPU accesses, then 1 debug access, repeating.
REQ-041 Scenario: cpu_rd=cpu_wr=1 simultaneously -> mem_we=1 on issue.
REQ-042 Scenario: nReset asserted in the second BUSY_CPU cycle -> all outputs 0 asynchronously; after release, IDLE, and a new CPU request takes MEM_LAT+2 stall cycles.
REQ-043 Scenario: dbg_req raised then dropped during CPU_BUSY -> no debug grant, starve_cnt cleared at the next IDLE.
